// File: rtl/ctrl_pkg.sv
// =====================================================================
// ctrl_pkg: shared widths and issue FSM state encoding.  Rev 1.0
// =====================================================================
`default_nettype none

package ctrl_pkg;
  localparam int INST_W_DEF = 17;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } issue_state_t;
endpackage

`default_nettype wire

// File: rtl/inst_skid_buf.sv
// =====================================================================
// inst_skid_buf: 2-entry FIFO, simultaneous push and pop.  Rev 1.0
// =====================================================================
`default_nettype none

module inst_skid_buf #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  localparam logic [1:0] CAP = DEPTH[1:0];

  logic [WIDTH-1:0] entry [2];
  logic             wr_idx;
  logic             rd_idx;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push && ((count != CAP) || do_pop);
  assign head    = entry[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) entry[i] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_idx] <= push_data;
        wr_idx        <= ~wr_idx;
      end
      if (do_pop) rd_idx <= ~rd_idx;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_issue.sv
// =====================================================================
// inst_issue: fetches instructions 0..inst_count-1 and issues them on a
// valid/ready port through a 2-entry prefetch buffer.
// Optional INST_ISSUE_LOOP_EN: wrapping fetch until stop_ex.  Rev 1.0
// =====================================================================
`default_nettype none

module inst_issue
  import ctrl_pkg::*;
#(
  parameter int INST_W    = INST_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_ex,
  input  logic [ADDR_W:0]   inst_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [INST_W-1:0] mem_rd_data,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid,
  input  logic              core_ready,
  output logic              busy,
  output logic              done
`ifdef INST_ISSUE_LOOP_EN
  ,
  input  logic              stop_ex
`endif
);

  localparam logic [2:0] CAP = 3'(BUF_DEPTH);

  issue_state_t    state;
  issue_state_t    state_nxt;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] rd_ptr_inc;
  logic [ADDR_W:0] rd_ptr_nxt;
  logic [ADDR_W:0] issued;
  logic [ADDR_W:0] issued_after;
  logic            inflight;
  logic [1:0]      buf_count;
  logic            pop;
  logic [2:0]      occ;

  inst_skid_buf #(
    .WIDTH (INST_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head      (inst_out),
    .count     (buf_count)
  );

  assign inst_valid   = (buf_count != 2'd0);
  assign pop          = inst_valid && core_ready;
  // Occupancy the buffer will have after this edge if no new read is issued;
  // counting the departing head lets reads stream back-to-back.
  assign occ          = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issued_after = issued + {{ADDR_W{1'b0}}, pop};
  assign rd_ptr_inc   = rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
`ifdef INST_ISSUE_LOOP_EN
  assign rd_ptr_nxt   = (rd_ptr_inc == cnt) ? '0 : rd_ptr_inc;
`else
  assign rd_ptr_nxt   = rd_ptr_inc;
`endif
  assign mem_rd_addr  = rd_ptr[ADDR_W-1:0];
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == FIN);

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start_ex) state_nxt = (inst_count == '0) ? FIN : RUN;
      end
      RUN: begin
`ifdef INST_ISSUE_LOOP_EN
        if (stop_ex)        state_nxt = DRAIN;
        else if (occ < CAP) mem_rd_en = 1'b1;
`else
        if (rd_ptr == cnt)  state_nxt = DRAIN;
        else if (occ < CAP) mem_rd_en = 1'b1;
`endif
      end
      DRAIN: begin
`ifdef INST_ISSUE_LOOP_EN
        if (occ == 3'd0) state_nxt = FIN;
`else
        if (issued_after == cnt) state_nxt = FIN;
`endif
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      issued   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_rd_en;
      if ((state == IDLE) && start_ex) begin
        cnt    <= inst_count;
        rd_ptr <= '0;
        issued <= '0;
      end else begin
        if (mem_rd_en) rd_ptr <= rd_ptr_nxt;
        if (pop)       issued <= issued_after;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_issue.sv
// =====================================================================
// tb_inst_issue: directed self-checking bench for inst_issue.  Rev 1.0
// =====================================================================
`default_nettype none

module tb_inst_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ex;
  logic [4:0]  inst_count;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [16:0] mem_rd_data;
  logic [16:0] inst_out;
  logic        inst_valid;
  logic        core_ready;
  logic        busy;
  logic        done;
  logic        stop_ex;

  logic [16:0] mem [16];

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          reads = 0;
  int          accs = 0;
  int          dones = 0;
  int          done_cyc = 0;
  int          last_acc_cyc = 0;
  int          unstable = 0;
  int          max_out = 0;
  logic        hold_pending = 1'b0;
  logic [16:0] held = '0;
  logic [16:0] acc_q [$];
  logic [3:0]  addr_q [$];

  always #5 clk = ~clk;

  inst_issue dut (
    .clk         (clk),
    .reset       (reset),
    .start_ex    (start_ex),
    .inst_count  (inst_count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid),
    .core_ready  (core_ready),
    .busy        (busy),
    .done        (done)
`ifdef INST_ISSUE_LOOP_EN
    ,
    .stop_ex     (stop_ex)
`endif
  );

  // 1-cycle-latency instruction memory
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Monitor samples pre-edge values of the DUT at each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (mem_rd_en) begin
      reads++;
      addr_q.push_back(mem_rd_addr);
    end
    if (inst_valid && core_ready) begin
      accs++;
      acc_q.push_back(inst_out);
      last_acc_cyc = cyc;
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (hold_pending && (!inst_valid || inst_out !== held)) unstable++;
    hold_pending = inst_valid && !core_ready;
    held = inst_out;
    if (reads - accs > max_out) max_out = reads - accs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = dones;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dones != d0) break;
    end
    chk(tag, 32'(dones - d0), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_addr"},  {28'd0, mem_rd_addr}, 32'd0);
    chk({tag, "_out"},   {15'd0, inst_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int a0;
    int d0;

    for (int i = 0; i < 16; i++) mem[i] = 17'(32'h1A5 + i * 32'h0B13);
    mem_rd_data = '0;
    reset       = 1'b1;
    start_ex    = 1'b0;
    inst_count  = '0;
    core_ready  = 1'b0;
    stop_ex     = 1'b0;

    // Reset state
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // 1: three instructions, ready high, plus ignored restart/count change
    inst_count = 5'd3; core_ready = 1'b1; start_ex = 1'b1;
    tick();                                            // T+1
    start_ex = 1'b0;
    chk("t1_rd_en_t1", {31'd0, mem_rd_en}, 32'd1);
    chk("t1_addr_t1", {28'd0, mem_rd_addr}, 32'd0);
    chk("t1_busy_t1", {31'd0, busy}, 32'd1);
    chk("t1_valid_t1", {31'd0, inst_valid}, 32'd0);
    tick();                                            // T+2
    inst_count = 5'd9; start_ex = 1'b1;
    chk("t1_addr_t2", {28'd0, mem_rd_addr}, 32'd1);
    chk("t1_valid_t2", {31'd0, inst_valid}, 32'd0);
    tick();                                            // T+3
    start_ex = 1'b0;
    chk("t1_addr_t3", {28'd0, mem_rd_addr}, 32'd2);
    chk("t1_valid_t3", {31'd0, inst_valid}, 32'd1);
    chk("t1_out0", {15'd0, inst_out}, {15'd0, mem[0]});
    tick();                                            // T+4
    chk("t1_rd_en_t4", {31'd0, mem_rd_en}, 32'd0);
    chk("t1_out1", {15'd0, inst_out}, {15'd0, mem[1]});
    tick();                                            // T+5
    chk("t1_out2", {15'd0, inst_out}, {15'd0, mem[2]});
    tick();                                            // T+6
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_fin", {31'd0, busy}, 32'd0);
    chk("t1_valid_fin", {31'd0, inst_valid}, 32'd0);
    tick();                                            // T+7
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_reads", 32'(reads), 32'd3);
    chk("t1_accs", 32'(accs), 32'd3);

    // 2: zero-length program
    r0 = reads; a0 = accs;
    inst_count = 5'd0; start_ex = 1'b1;
    tick();
    start_ex = 1'b0;
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_done_pulse", {31'd0, done}, 32'd0);
    chk("t2_no_reads", 32'(reads - r0), 32'd0);
    chk("t2_no_valid", 32'(accs - a0), 32'd0);

    // 3: full 16-entry program, ready toggling
    tick();
    acc_q.delete(); addr_q.delete();
    max_out = 0; unstable = 0;
    inst_count = 5'd16; start_ex = 1'b1; core_ready = 1'b1;
    tick();
    start_ex = 1'b0;
    d0 = dones;
    for (int i = 0; i < 200; i++) begin
      core_ready = i[0];
      tick();
      if (dones != d0) break;
    end
    chk("t3_done", 32'(dones - d0), 32'd1);
    chk("t3_count", 32'(acc_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_inst%0d", i), {15'd0, acc_q[i]}, {15'd0, mem[i]});
      chk($sformatf("t3_addr%0d", i), {28'd0, addr_q[i]}, 32'(i));
    end
    chk("t3_stable", 32'(unstable), 32'd0);
    chk("t3_capacity", {31'd0, (max_out <= 2)}, 32'd1);
    core_ready = 1'b1;
    tick();

    // 4: stalled consumer
    acc_q.delete();
    r0 = reads;
    core_ready = 1'b0; inst_count = 5'd4; start_ex = 1'b1;
    tick();
    start_ex = 1'b0;
    repeat (10) tick();
    chk("t4_stall_reads", 32'(reads - r0), 32'd2);
    chk("t4_stall_valid", {31'd0, inst_valid}, 32'd1);
    chk("t4_stall_head", {15'd0, inst_out}, {15'd0, mem[0]});
    core_ready = 1'b1;
    wait_done("t4_done", 20);
    chk("t4_reads", 32'(reads - r0), 32'd4);
    chk("t4_count", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_inst%0d", i), {15'd0, acc_q[i]}, {15'd0, mem[i]});
    chk("t4_done_timing", 32'(done_cyc), 32'(last_acc_cyc + 1));
    tick();

    // 5: asynchronous reset mid-run, then restart
    a0 = accs;
    inst_count = 5'd8; core_ready = 1'b1; start_ex = 1'b1;
    tick();
    start_ex = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (accs - a0 >= 2) break;
      tick();
    end
    chk("t5_two_issued", 32'(accs - a0), 32'd2);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    d0 = dones;
    #3 reset = 1'b1;
    #1;
    chk_idle_outputs("t5_async");
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t5_no_done", 32'(dones - d0), 32'd0);
    acc_q.delete();
    inst_count = 5'd3; start_ex = 1'b1;
    tick();
    start_ex = 1'b0;
    chk("t5_restart_rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("t5_restart_addr", {28'd0, mem_rd_addr}, 32'd0);
    wait_done("t5_done", 20);
    chk("t5_count", 32'(acc_q.size()), 32'd3);
    chk("t5_first", {15'd0, acc_q[0]}, {15'd0, mem[0]});
    tick();

`ifdef INST_ISSUE_LOOP_EN
    // 6: looped fetch of two entries, stopped at the fifth issue
    acc_q.delete(); addr_q.delete();
    inst_count = 5'd2; core_ready = 1'b1; start_ex = 1'b1;
    tick();                                            // T+1
    start_ex = 1'b0;
    repeat (6) tick();                                 // T+7: fifth issue
    stop_ex = 1'b1;
    tick();
    stop_ex = 1'b0;
    wait_done("t6_done", 10);
    chk("t6_count", 32'(acc_q.size()), 32'd6);
    chk("t6_reads", 32'(addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_addr%0d", i), {28'd0, addr_q[i]}, 32'(i % 2));
      chk($sformatf("t6_inst%0d", i), {15'd0, acc_q[i]}, {15'd0, mem[i % 2]});
    end
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
